// File: rtl/roba_pipe_if.sv
// Handshake bundle for roba_pipe: operand/tag input channel and product/tag output channel.
interface roba_pipe_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_mode;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_r;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_r, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_r, out_tag
   );
endinterface

// File: rtl/roba_pipe.sv
// 3-stage rounding-based approximate multiplier (A*B ~ Ar*B + Br*A - Ar*Br), shifts only.
// Define ROBA_PIPE_EXACT_EN to build the exact product path selected by in_mode=1.
module roba_pipe #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input logic       clk,
   input logic       rst_n,
   roba_pipe_if.slave bus
);
   localparam int PW = 2*WIDTH + 2;

   // Nearest power of two as a one-hot: 2^(k+1) when the bit below the MSB is set (k>=2).
   function automatic logic [WIDTH:0] f_round(input logic [WIDTH-1:0] x);
      logic [WIDTH:0] r;
      r = '0;
      if (x[0]) r[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++)
         if (x[i]) begin
            r = '0;
            if (i >= 2 && x[i-1]) r[i+1] = 1'b1;
            else                  r[i]   = 1'b1;
         end
      return r;
   endfunction

   function automatic logic [PW-1:0] f_shl(input logic [WIDTH:0] oh, input logic [PW-1:0] v);
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i <= WIDTH; i++)
         if (oh[i]) r = v << i;
      return r;
   endfunction

   logic                 w_en;
   logic [3:1]           r_vld;
   logic [WIDTH-1:0]     r1_a, r1_b;
   logic [WIDTH:0]       r1_ar, r1_br;
   logic [TAG_W-1:0]     r1_tag, r2_tag, r3_tag;
   logic [PW-1:0]        r2_p, r2_z;
   logic [2*WIDTH-1:0]   r3_r;
   logic [PW-1:0]        w_p, w_z, w_diff;
   logic                 w_unused;

   assign w_en          = !r_vld[3] | bus.out_ready;
   assign bus.in_ready  = w_en;
   assign bus.out_valid = r_vld[3];
   assign bus.out_r     = r3_r;
   assign bus.out_tag   = r3_tag;

   assign w_p    = f_shl(r1_ar, {{(PW-WIDTH){1'b0}}, r1_b})
                 + f_shl(r1_br, {{(PW-WIDTH){1'b0}}, r1_a});
   assign w_z    = f_shl(r1_br, {{(PW-WIDTH-1){1'b0}}, r1_ar});
   // P >= Z always, and the difference fits in 2*WIDTH bits for legal inputs.
   assign w_diff = r2_p - r2_z;

`ifdef ROBA_PIPE_EXACT_EN
   logic               r1_mode, r2_mode;
   logic [WIDTH-1:0]   r2_a, r2_b;
   logic [2*WIDTH-1:0] w_exact;
   assign w_exact  = {{WIDTH{1'b0}}, r2_a} * {{WIDTH{1'b0}}, r2_b};
   assign w_unused = &{1'b0, w_diff[PW-1:2*WIDTH]};
`else
   assign w_unused = &{1'b0, w_diff[PW-1:2*WIDTH], bus.in_mode};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r1_a   <= '0;
         r1_b   <= '0;
         r1_ar  <= '0;
         r1_br  <= '0;
         r1_tag <= '0;
         r2_p   <= '0;
         r2_z   <= '0;
         r2_tag <= '0;
         r3_r   <= '0;
         r3_tag <= '0;
`ifdef ROBA_PIPE_EXACT_EN
         r1_mode <= 1'b0;
         r2_mode <= 1'b0;
         r2_a    <= '0;
         r2_b    <= '0;
`endif
      end else if (w_en) begin
         r_vld  <= {r_vld[2:1], bus.in_valid};
         r1_a   <= bus.in_a;
         r1_b   <= bus.in_b;
         r1_ar  <= f_round(bus.in_a);
         r1_br  <= f_round(bus.in_b);
         r1_tag <= bus.in_tag;
         r2_p   <= w_p;
         r2_z   <= w_z;
         r2_tag <= r1_tag;
         r3_tag <= r2_tag;
`ifdef ROBA_PIPE_EXACT_EN
         r1_mode <= bus.in_mode;
         r2_mode <= r1_mode;
         r2_a    <= r1_a;
         r2_b    <= r1_b;
         r3_r    <= r2_mode ? w_exact : w_diff[2*WIDTH-1:0];
`else
         r3_r    <= w_diff[2*WIDTH-1:0];
`endif
      end
   end
endmodule

// File: tb/tb_roba_pipe.sv
// Directed bench for roba_pipe: spec vectors, stall/ordering, async reset, strided 8-bit sweep.
module tb_roba_pipe;
   localparam int W = 8;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   roba_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();
   roba_pipe #(.WIDTH(W), .TAG_W(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Independent reference: rounding via $clog2, products with real multiplies.
   function automatic longint rnd(input longint x);
      int k;
      if (x == 0) return 0;
      k = $clog2(x + 1) - 1;
      if (k >= 2 && ((x >> (k - 1)) & 1) == 1) return longint'(1) << (k + 1);
      return longint'(1) << k;
   endfunction

   function automatic logic [15:0] model(input int a, input int b, input logic m);
      longint ar, br, p;
`ifdef ROBA_PIPE_EXACT_EN
      if (m) return 16'(a * b);
`else
      if (m) ar = 0;
`endif
      ar = rnd(a);
      br = rnd(b);
      p  = ar * b + br * a - ar * br;
      return 16'(p);
   endfunction

   task automatic run_one(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic m, input logic [3:0] tg, input logic [15:0] exp);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_mode   = m;
      bus.in_tag    = tg;
      step();
      bus.in_valid = 1'b0;
      step();
      check({nm, "_lat2_valid"}, bus.out_valid, 1'b0);
      step();
      check({nm, "_lat3_valid"}, bus.out_valid, 1'b1);
      check({nm, "_r"}, bus.out_r, exp);
      check({nm, "_tag"}, bus.out_tag, tg);
      step();
      check({nm, "_drain"}, bus.out_valid, 1'b0);
   endtask

   task automatic gen(input int kind, input int idx, output logic [7:0] a, output logic [7:0] b,
                      output logic m, output logic [3:0] tg);
      if (kind == 0) begin
         a = 8'(idx * 17 + 3);
         b = 8'(idx * 29 + 5);
      end else begin
         a = 8'(idx % 256);
         b = 8'((idx / 256) * 5);
      end
      m  = idx[0];
      tg = idx[3:0];
   endtask

   // Streams nops operations through a scoreboard; kind 0 = back-to-back with fixed stall window.
   task automatic stream(input int kind, input int nops, input int budget);
      logic [15:0] qr[$];
      logic [3:0]  qt[$];
      int          sent = 0, got = 0, cyc = 0;
      logic        held = 1'b0;
      logic [7:0]  a, b;
      logic        m;
      logic [3:0]  tg;
      while (got < nops && cyc < budget) begin
         if (sent < nops && (held || kind == 0 || $urandom_range(0, 7) != 0)) begin
            gen(kind, sent, a, b, m, tg);
            bus.in_valid = 1'b1;
            bus.in_a     = a;
            bus.in_b     = b;
            bus.in_mode  = m;
            bus.in_tag   = tg;
         end else
            bus.in_valid = 1'b0;
         if (kind == 0) bus.out_ready = !(cyc >= 4 && cyc <= 9);
         else           bus.out_ready = ($urandom_range(0, 7) != 0);
         #1;
         if (kind == 0)
            check("b2b_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         if (bus.out_valid && qr.size() == 0)
            check("no_spurious_out", bus.out_valid, 1'b0);
         else if (bus.out_valid) begin
            check(kind == 0 ? "b2b_r" : "sweep_r", bus.out_r, qr[0]);
            check(kind == 0 ? "b2b_tag" : "sweep_tag", bus.out_tag, qt[0]);
            if (bus.out_ready) begin
               void'(qr.pop_front());
               void'(qt.pop_front());
               got++;
            end
         end
         held = bus.in_valid && !bus.in_ready;
         if (bus.in_valid && bus.in_ready) begin
            qr.push_back(model(bus.in_a, bus.in_b, bus.in_mode));
            qt.push_back(bus.in_tag);
            sent++;
         end
         cyc++;
         @(posedge clk);
         #1;
      end
      check(kind == 0 ? "b2b_count" : "sweep_count", got, nops);
      check(kind == 0 ? "b2b_left" : "sweep_left", qr.size(), 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
   endtask

   initial begin
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_mode   = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_r", bus.out_r, 16'd0);
      check("rst_out_tag", bus.out_tag, 4'd0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      run_one("a3b5_m0", 8'd3, 8'd5, 1'b0, 4'h1, 16'd14);
`ifdef ROBA_PIPE_EXACT_EN
      run_one("a3b5_m1", 8'd3, 8'd5, 1'b1, 4'h2, 16'd15);
      run_one("a255b255_m1", 8'd255, 8'd255, 1'b1, 4'h5, 16'd65025);
`else
      run_one("a3b5_m1", 8'd3, 8'd5, 1'b1, 4'h2, 16'd14);
      run_one("a255b255_m1", 8'd255, 8'd255, 1'b1, 4'h5, 16'd65024);
`endif
      run_one("a6b12_m0", 8'd6, 8'd12, 1'b0, 4'h3, 16'd64);
      run_one("a255b255_m0", 8'd255, 8'd255, 1'b0, 4'h4, 16'd65024);
      run_one("a0b200_m0", 8'd0, 8'd200, 1'b0, 4'h6, 16'd0);
      run_one("a0b200_m1", 8'd0, 8'd200, 1'b1, 4'h7, 16'd0);
      run_one("a1b1_m0", 8'd1, 8'd1, 1'b0, 4'h8, 16'd1);
      run_one("a1b1_m1", 8'd1, 8'd1, 1'b1, 4'h9, 16'd1);
      run_one("a200b0_m0", 8'd200, 8'd0, 1'b0, 4'hA, 16'd0);

      stream(0, 8, 100);

      // Three operations in flight, then asynchronous reset between clock edges.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_mode   = 1'b0;
      bus.in_a = 8'd255; bus.in_b = 8'd255; bus.in_tag = 4'hC;
      step();
      bus.in_a = 8'd6;   bus.in_b = 8'd12;  bus.in_tag = 4'hD;
      step();
      bus.in_a = 8'd3;   bus.in_b = 8'd5;   bus.in_tag = 4'hE;
      step();
      bus.in_valid = 1'b0;
      check("pre_rst_valid", bus.out_valid, 1'b1);
      check("pre_rst_r", bus.out_r, 16'd65024);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 1'b0);
      check("midrst_out_r", bus.out_r, 16'd0);
      check("midrst_out_tag", bus.out_tag, 4'd0);
      check("midrst_in_ready", bus.in_ready, 1'b1);
      step();
      check("inrst_in_ready", bus.in_ready, 1'b1);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("no_stale_valid", bus.out_valid, 1'b0);
      end
      run_one("post_rst", 8'd6, 8'd12, 1'b0, 4'hB, 16'd64);

      stream(1, 256 * 52, 40000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
